sd_init_ctrl: RTL and testbench

- Sequencer that drives the SD_CMD command transmitter through the SPI-mode SD card initialisation flow.
- Flow: power-up dummy clocks, CMD0, CMD8, the CMD55/ACMD41 loop, then CMD16.
- Sits between the top-level storage logic and SD_CMD. It owns card chip-select, supplies index/argument/isStart, and checks R1 bytes from the response receiver.
- Reports ready or a coded error.

---
 rtl/sd_init_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_sd_init_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_init_ctrl.sv
// SPI-mode SD card init sequencer: dummy clocks, CMD0, CMD8, CMD55/ACMD41 loop, CMD16.
// Drives SD_CMD via index/argument/start handshake, owns chip-select, checks R1 bytes.
module sd_init_ctrl #(
  parameter int DUMMY_CLKS   = 80,
  parameter int RESP_TIMEOUT = 1024,
  parameter int MAX_RETRY    = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [5:0]  cmdIndex,
  output logic [31:0] cmdArgument,
  output logic        cmdStart,
  input  logic        cmdBusy,
  input  logic        cmdFinish,
  input  logic        respValid,
  input  logic [7:0]  resp,
  output logic        CS,
  output logic        isBusy,
  output logic        isReady,
  output logic        isError,
  output logic [2:0]  errCode
);

  typedef enum logic [2:0] {
    IDLE, POWERUP, ISSUE, WAIT_FIN, WAIT_RESP, DONE, ERROR
  } state_t;

  typedef enum logic [2:0] {
    S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD16
  } step_t;

  state_t      state_q;
  step_t       step_q;
  logic [15:0] cnt_q;
  logic [15:0] retry_q;
  logic [5:0]  idx_q;
  logic [31:0] arg_q;
  logic        start_q;
  logic        cs_q;
  logic        busy_q;
  logic        ready_q;
  logic        error_q;
  logic [2:0]  code_q;

  // SD_CMD busy carries no decision here; the finish strobe is the handshake.
  logic unused_busy;
  assign unused_busy = cmdBusy;

  logic [5:0]  idx_d;
  logic [31:0] arg_d;
  always_comb begin
    idx_d = 6'd0;
    arg_d = 32'h0000_0000;
    case (step_q)
      S_CMD0:   begin idx_d = 6'd0;  arg_d = 32'h0000_0000; end
      S_CMD8:   begin idx_d = 6'd8;  arg_d = 32'h0000_01AA; end
      S_CMD55:  begin idx_d = 6'd55; arg_d = 32'h0000_0000; end
      S_ACMD41: begin idx_d = 6'd41; arg_d = 32'h4000_0000; end
      S_CMD16:  begin idx_d = 6'd16; arg_d = 32'h0000_0200; end
      default:  begin idx_d = 6'd0;  arg_d = 32'h0000_0000; end
    endcase
  end

  // R1 evaluation: whether the byte is acceptable, where to go next, and the code if not.
  logic        resp_ok;
  logic        done_d;
  step_t       step_d;
  logic [2:0]  code_d;
  logic [15:0] retry_d;
  always_comb begin
    resp_ok = 1'b0;
    done_d  = 1'b0;
    step_d  = step_q;
    code_d  = 3'd0;
    retry_d = retry_q;
    case (step_q)
      S_CMD0:  begin resp_ok = (resp == 8'h01); step_d = S_CMD8;  code_d = 3'd2; end
      S_CMD8:  begin resp_ok = (resp == 8'h01); step_d = S_CMD55; code_d = 3'd3; end
      S_CMD55: begin
        resp_ok = (resp == 8'h01) || (resp == 8'h00);
        step_d  = S_ACMD41;
        code_d  = 3'd4;
      end
      S_ACMD41: begin
        code_d = 3'd5;
        if (resp == 8'h00) begin
          resp_ok = 1'b1;
          step_d  = S_CMD16;
        end else if (resp == 8'h01) begin
          retry_d = retry_q + 16'd1;
          resp_ok = (retry_d != 16'(MAX_RETRY));
          step_d  = S_CMD55;
        end
      end
      S_CMD16: begin resp_ok = (resp == 8'h00); done_d = 1'b1; code_d = 3'd6; end
      default: begin resp_ok = 1'b0; code_d = 3'd0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= S_CMD0;
      cnt_q   <= 16'd0;
      retry_q <= 16'd0;
      idx_q   <= 6'd0;
      arg_q   <= 32'h0000_0000;
      start_q <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      code_q  <= 3'd0;
    end else begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state_q <= POWERUP;
            cnt_q   <= 16'd0;
            retry_q <= 16'd0;
            cs_q    <= 1'b1;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            code_q  <= 3'd0;
          end
        end
        POWERUP: begin
          if (cnt_q == 16'(DUMMY_CLKS - 1)) begin
            cnt_q   <= 16'd0;
            cs_q    <= 1'b0;
            step_q  <= S_CMD0;
            state_q <= ISSUE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ISSUE: begin
          idx_q   <= idx_d;
          arg_q   <= arg_d;
          start_q <= 1'b1;
          state_q <= WAIT_FIN;
        end
        WAIT_FIN: begin
          if (cmdFinish) begin
            start_q <= 1'b0;
            cnt_q   <= 16'd0;
            state_q <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          // A response arriving on the terminal-count cycle takes priority over the timeout.
          if (respValid) begin
            retry_q <= retry_d;
            if (!resp_ok) begin
              state_q <= ERROR;
              code_q  <= code_d;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
              cs_q    <= 1'b1;
            end else if (done_d) begin
              state_q <= DONE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              step_q  <= step_d;
              state_q <= ISSUE;
            end
          end else if (cnt_q == 16'(RESP_TIMEOUT - 1)) begin
            state_q <= ERROR;
            code_q  <= 3'd1;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            cs_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmdIndex    = idx_q;
  assign cmdArgument = arg_q;
  assign cmdStart    = start_q;
  assign CS          = cs_q;
  assign isBusy      = busy_q;
  assign isReady     = ready_q;
  assign isError     = error_q;
  assign errCode     = code_q;

endmodule

// File: tb/tb_sd_init_ctrl.sv
// Scoreboard bench for sd_init_ctrl: directed responder, command/status queues checked by a monitor.
module tb_sd_init_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, cmdBusy, cmdFinish, respValid;
  logic [7:0]  resp;
  logic [5:0]  cmdIndex;
  logic [31:0] cmdArgument;
  logic        cmdStart, CS, isBusy, isReady, isError;
  logic [2:0]  errCode;

  int errors = 0;
  int checks = 0;

  typedef struct packed { logic [5:0] idx; logic [31:0] arg; } cmd_t;
  typedef struct packed { logic rdy; logic err; logic [2:0] code; logic cs; } end_t;

  cmd_t exp_cmd[$];
  end_t exp_end[$];

  always #5 clk = ~clk;

  sd_init_ctrl #(.DUMMY_CLKS(80), .RESP_TIMEOUT(16), .MAX_RETRY(3)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cmdIndex(cmdIndex), .cmdArgument(cmdArgument), .cmdStart(cmdStart),
    .cmdBusy(cmdBusy), .cmdFinish(cmdFinish), .respValid(respValid), .resp(resp),
    .CS(CS), .isBusy(isBusy), .isReady(isReady), .isError(isError), .errCode(errCode)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a rising cmdStart consumes one expected command; isBusy falling consumes one end status.
  logic prev_start = 1'b0;
  logic prev_busy  = 1'b0;
  cmd_t got_cmd;
  end_t got_end;
  always @(negedge clk) begin
    if (cmdStart === 1'b1 && prev_start !== 1'b1) begin
      if (exp_cmd.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_cmdStart: got index %0d, expected no command", cmdIndex);
      end else begin
        got_cmd = exp_cmd.pop_front();
        chk("cmd_index", 32'(cmdIndex), 32'(got_cmd.idx));
        chk("cmd_argument", cmdArgument, got_cmd.arg);
      end
    end
    if (isBusy === 1'b0 && prev_busy === 1'b1) begin
      if (exp_end.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_end: got ready=%b error=%b code=%0d, expected still busy",
                 isReady, isError, errCode);
      end else begin
        got_end = exp_end.pop_front();
        chk("end_isReady", 32'(isReady), 32'(got_end.rdy));
        chk("end_isError", 32'(isError), 32'(got_end.err));
        chk("end_errCode", 32'(errCode), 32'(got_end.code));
        chk("end_CS", 32'(CS), 32'(got_end.cs));
      end
    end
    prev_start = cmdStart;
    prev_busy  = isBusy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [5:0] idx, input logic [31:0] arg);
    exp_cmd.push_back(cmd_t'{idx, arg});
  endtask

  task automatic push_end(input logic rdy, input logic err, input logic [2:0] code, input logic cs);
    exp_end.push_back(end_t'{rdy, err, code, cs});
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic count_cs();
    int n = 0;
    while (isBusy === 1'b1 && CS === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    chk("cs_high_cycles", n, 80);
  endtask

  task automatic wait_start(output bit ok);
    int n = 0;
    while (cmdStart !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    ok = (cmdStart === 1'b1);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_cmdStart: got none within %0d cycles, expected cmdStart", n);
    end
  endtask

  // One command handshake: hold off finish, check start is held then dropped, reply after rdly cycles.
  task automatic answer(input logic [7:0] r, input int rdly);
    bit ok;
    wait_start(ok);
    if (!ok) return;
    repeat (3) tick();
    chk("start_held", 32'(cmdStart), 1);
    cmdFinish = 1'b1;
    tick();
    cmdFinish = 1'b0;
    chk("start_drop", 32'(cmdStart), 0);
    repeat (rdly) tick();
    resp      = r;
    respValid = 1'b1;
    tick();
    respValid = 1'b0;
    resp      = 8'hFF;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (isBusy === 1'b1 && n < 600) begin
      tick();
      n++;
    end
    chk("busy_drop", 32'(isBusy), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmdIndex"}, 32'(cmdIndex), 0);
    chk({tag, "_cmdArgument"}, cmdArgument, 0);
    chk({tag, "_cmdStart"}, 32'(cmdStart), 0);
    chk({tag, "_CS"}, 32'(CS), 1);
    chk({tag, "_isBusy"}, 32'(isBusy), 0);
    chk({tag, "_isReady"}, 32'(isReady), 0);
    chk({tag, "_isError"}, 32'(isError), 0);
    chk({tag, "_errCode"}, 32'(errCode), 0);
  endtask

  initial begin
    bit ok;
    int n;
    reset = 1'b1; start = 1'b0; cmdBusy = 1'b0; cmdFinish = 1'b0;
    respValid = 1'b0; resp = 8'h00;
    repeat (2) tick();
    chk_reset_vals("reset");
    reset = 1'b0;
    tick();

    // Nominal flow with one busy ACMD41 and a stray start mid-sequence.
    push_cmd(6'd0, 32'h0); push_cmd(6'd8, 32'h1AA); push_cmd(6'd55, 32'h0);
    push_cmd(6'd41, 32'h4000_0000); push_cmd(6'd55, 32'h0);
    push_cmd(6'd41, 32'h4000_0000); push_cmd(6'd16, 32'h200);
    push_end(1'b1, 1'b0, 3'd0, 1'b0);
    kick();
    count_cs();
    answer(8'h01, 2);
    answer(8'h01, 1);
    kick();
    answer(8'h01, 0);
    answer(8'h01, 3);
    answer(8'h01, 1);
    answer(8'h00, 2);
    answer(8'h00, 1);
    wait_idle();
    chk("nominal_isReady", 32'(isReady), 1);
    chk("nominal_CS", 32'(CS), 0);

    // Restart from DONE, then ACMD41 stays busy until the retry limit.
    push_cmd(6'd0, 32'h0); push_cmd(6'd8, 32'h1AA);
    for (int i = 0; i < 3; i++) begin
      push_cmd(6'd55, 32'h0);
      push_cmd(6'd41, 32'h4000_0000);
    end
    push_end(1'b0, 1'b1, 3'd5, 1'b1);
    kick();
    chk("restart_ready_cleared", 32'(isReady), 0);
    count_cs();
    for (int i = 0; i < 8; i++) answer(8'h01, 1);
    wait_idle();

    // CMD8 illegal-command reply (v1 card).
    push_cmd(6'd0, 32'h0); push_cmd(6'd8, 32'h1AA);
    push_end(1'b0, 1'b1, 3'd3, 1'b1);
    kick();
    chk("restart_error_cleared", 32'(isError), 0);
    answer(8'h01, 1);
    answer(8'h05, 1);
    wait_idle();
    repeat (20) tick();
    chk("cmd8_no_more_start", 32'(cmdStart), 0);

    // Response timeout after CMD0.
    push_cmd(6'd0, 32'h0);
    push_end(1'b0, 1'b1, 3'd1, 1'b1);
    kick();
    wait_start(ok);
    repeat (2) tick();
    cmdFinish = 1'b1;
    tick();
    cmdFinish = 1'b0;
    n = 0;
    while (isError !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, 16);

    // Reply on the terminal-count cycle wins; then reset during CMD55 WAIT_FIN.
    push_cmd(6'd0, 32'h0); push_cmd(6'd8, 32'h1AA); push_cmd(6'd55, 32'h0);
    push_end(1'b0, 1'b0, 3'd0, 1'b1);
    kick();
    answer(8'h01, 15);
    answer(8'h01, 1);
    wait_start(ok);
    tick();
    reset = 1'b1;
    tick();
    chk_reset_vals("midreset");
    reset = 1'b0;
    repeat (3) tick();

    chk("cmd_queue_drained", exp_cmd.size(), 0);
    chk("end_queue_drained", exp_end.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
